// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch sequencer state encoding.
package cpu_pkg;

   localparam int unsigned ADDR_WIDTH        = 32;
   localparam int unsigned INSTRUCTION_WIDTH = 32;
   localparam int unsigned INSTR_BYTES       = 4;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the PC, issues one instruction-memory read at a
// time and presents the fetched word to decode through a one-entry register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         next_stall,
   output logic                         done_next,
   input  logic                         redirect,
   input  logic [ADDR_WIDTH-1:0]        redirect_target,
   output logic                         imem_req_valid,
   output logic [ADDR_WIDTH-1:0]        imem_req_addr,
   input  logic                         imem_req_ready,
   input  logic                         imem_resp_valid,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
   output logic [ADDR_WIDTH-1:0]        program_count_out,
   output logic                         program_count_valid_out,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
   output logic                         instruction_data_valid_out
);

   fetch_state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]        req_pc_q, req_pc_d;
   logic                         drop_pending_q, drop_pending_d;
   logic                         done_q, done_d;
   logic [ADDR_WIDTH-1:0]        out_pc_q, out_pc_d;
   logic                         out_pc_valid_q, out_pc_valid_d;
   logic [INSTRUCTION_WIDTH-1:0] out_instr_q, out_instr_d;
   logic                         out_instr_valid_q, out_instr_valid_d;

   logic transfer_next;
   logic slot_free;
   logic misaligned;
   logic req_valid;
   logic req_accept;

   // Handshake qualifiers: the slot may be refilled when empty or draining this cycle.
   always_comb begin
      transfer_next = done_q && !next_stall;
      slot_free     = !done_q || transfer_next;
      misaligned    = (pc_q[1:0] != 2'b00);
      req_valid     = (state_q == ISSUE) && !misaligned && slot_free && !redirect;
      req_accept    = req_valid && imem_req_ready;
   end

   // Next-state logic for the sequencer, PC and output register; redirect overrides all.
   always_comb begin
      state_d           = state_q;
      pc_d              = pc_q;
      req_pc_d          = req_pc_q;
      drop_pending_d    = drop_pending_q;
      done_d            = done_q && !transfer_next;
      out_pc_d          = out_pc_q;
      out_pc_valid_d    = out_pc_valid_q;
      out_instr_d       = out_instr_q;
      out_instr_valid_d = out_instr_valid_q;

      case (state_q)
         ISSUE: begin
            if (misaligned && slot_free) begin
               out_pc_d          = pc_q;
               out_pc_valid_d    = 1'b1;
               out_instr_valid_d = 1'b0;
               done_d            = 1'b1;
               state_d           = FAULT;
            end else if (req_accept) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + ADDR_WIDTH'(INSTR_BYTES);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               if (drop_pending_q) begin
                  drop_pending_d = 1'b0;
               end else begin
                  out_pc_d          = req_pc_q;
                  out_pc_valid_d    = 1'b1;
                  out_instr_d       = imem_resp_data;
                  out_instr_valid_d = 1'b1;
                  done_d            = 1'b1;
               end
               state_d = ISSUE;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = ISSUE;
         end
      endcase

      // No request can be accepted in a redirect cycle, so the only live request is
      // one still waiting in WAIT; a response landing this same cycle retires it.
      if (redirect) begin
         pc_d              = redirect_target;
         done_d            = 1'b0;
         out_pc_valid_d    = 1'b0;
         out_instr_valid_d = 1'b0;
         if ((state_q == WAIT) && !imem_resp_valid) begin
            drop_pending_d = 1'b1;
            state_d        = WAIT;
         end else begin
            drop_pending_d = 1'b0;
            state_d        = ISSUE;
         end
      end
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ISSUE;
         pc_q              <= RESET_VECTOR;
         req_pc_q          <= '0;
         drop_pending_q    <= 1'b0;
         done_q            <= 1'b0;
         out_pc_q          <= '0;
         out_pc_valid_q    <= 1'b0;
         out_instr_q       <= '0;
         out_instr_valid_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         req_pc_q          <= req_pc_d;
         drop_pending_q    <= drop_pending_d;
         done_q            <= done_d;
         out_pc_q          <= out_pc_d;
         out_pc_valid_q    <= out_pc_valid_d;
         out_instr_q       <= out_instr_d;
         out_instr_valid_q <= out_instr_valid_d;
      end
   end

   assign imem_req_valid             = req_valid;
   assign imem_req_addr              = pc_q;
   assign done_next                  = done_q;
   assign program_count_out          = out_pc_q;
   assign program_count_valid_out    = out_pc_valid_q;
   assign instruction_data_out       = out_instr_q;
   assign instruction_data_valid_out = out_instr_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order memory responder.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        next_stall;
   logic        done_next;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] program_count_out;
   logic        program_count_valid_out;
   logic [31:0] instruction_data_out;
   logic        instruction_data_valid_out;

   int unsigned tests_run;
   int unsigned tests_failed;

   logic        pend;
   int unsigned pend_cnt;
   int unsigned resp_delay;
   logic [31:0] pend_addr;

   fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .next_stall                 (next_stall),
      .done_next                  (done_next),
      .redirect                   (redirect),
      .redirect_target            (redirect_target),
      .imem_req_valid             (imem_req_valid),
      .imem_req_addr              (imem_req_addr),
      .imem_req_ready             (imem_req_ready),
      .imem_resp_valid            (imem_resp_valid),
      .imem_resp_data             (imem_resp_data),
      .program_count_out          (program_count_out),
      .program_count_valid_out    (program_count_valid_out),
      .instruction_data_out       (instruction_data_out),
      .instruction_data_valid_out (instruction_data_valid_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0000_0013;
         32'h0000_0004: mem_word = 32'h0010_0093;
         32'h0000_0008: mem_word = 32'h0020_0113;
         32'h0000_0100: mem_word = 32'h0050_0113;
         32'h0000_0200: mem_word = 32'h00A0_0193;
         32'hFFFF_FFFC: mem_word = 32'h0000_006F;
         default:       mem_word = 32'hDEAD_BEEF;
      endcase
   endfunction

   // One clock: note acceptance before the edge, then drive the responder after it.
   task automatic step();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (acc === 1'b1) begin
         pend      = 1'b1;
         pend_cnt  = resp_delay;
         pend_addr = a;
      end
      if (pend) begin
         if (pend_cnt <= 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr);
            pend            = 1'b0;
         end else begin
            pend_cnt = pend_cnt - 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_req_ready = 1'b0;
      step(); step();
      tests_run++; if (done_next !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_next); end
      tests_run++; if (program_count_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_pcv: got %b want 0", program_count_valid_out); end
      tests_run++; if (instruction_data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_idv: got %b want 0", instruction_data_valid_out); end
      rst = 1'b0; imem_req_ready = 1'b1; pend = 1'b0; imem_resp_valid = 1'b0;
      #1;
      tests_run++; if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 1", imem_req_valid); end
      tests_run++; if (imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
   endtask

   task automatic test_basic_fetch();
      resp_delay = 1;
      step();
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_wait_noreq: got %b want 0", imem_req_valid); end
      tests_run++; if (done_next !== 1'b0) begin tests_failed++; $display("FAIL basic_done0_a: got %b want 0", done_next); end
      step();
      tests_run++; if (done_next !== 1'b1) begin tests_failed++; $display("FAIL basic_done1_a: got %b want 1", done_next); end
      tests_run++; if (program_count_out !== 32'h0) begin tests_failed++; $display("FAIL basic_pc0: got %h want 00000000", program_count_out); end
      tests_run++; if (instruction_data_out !== 32'h0000_0013) begin tests_failed++; $display("FAIL basic_instr0: got %h want 00000013", instruction_data_out); end
      tests_run++; if ({program_count_valid_out, instruction_data_valid_out} !== 2'b11) begin tests_failed++; $display("FAIL basic_valids0: got %b want 11", {program_count_valid_out, instruction_data_valid_out}); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin tests_failed++; $display("FAIL basic_req4: got %b/%h want 1/00000004", imem_req_valid, imem_req_addr); end
      step();
      tests_run++; if (done_next !== 1'b0) begin tests_failed++; $display("FAIL basic_done0_b: got %b want 0", done_next); end
      step();
      tests_run++; if (done_next !== 1'b1) begin tests_failed++; $display("FAIL basic_done1_b: got %b want 1", done_next); end
      tests_run++; if (program_count_out !== 32'h4) begin tests_failed++; $display("FAIL basic_pc4: got %h want 00000004", program_count_out); end
      tests_run++; if (instruction_data_out !== 32'h0010_0093) begin tests_failed++; $display("FAIL basic_instr4: got %h want 00100093", instruction_data_out); end
   endtask

   task automatic test_stall();
      next_stall = 1'b1;
      #1;
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_noreq_pre: got %b want 0", imem_req_valid); end
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++; if (done_next !== 1'b1 || program_count_out !== 32'h4 || instruction_data_out !== 32'h0010_0093) begin tests_failed++; $display("FAIL stall_hold[%0d]: got %b/%h/%h want 1/00000004/00100093", i, done_next, program_count_out, instruction_data_out); end
         tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_noreq[%0d]: got %b want 0", i, imem_req_valid); end
      end
      next_stall = 1'b0;
      #1;
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin tests_failed++; $display("FAIL stall_release_req: got %b/%h want 1/00000008", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_redirect_drop();
      resp_delay = 3;
      step();
      tests_run++; if (done_next !== 1'b0 || imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_wait8: got done %b req %b want 0/0", done_next, imem_req_valid); end
      redirect = 1'b1; redirect_target = 32'h100;
      step();
      redirect = 1'b0;
      #1;
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_still_wait: got %b want 0", imem_req_valid); end
      step();
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_still_wait2: got %b want 0", imem_req_valid); end
      step();
      tests_run++; if (done_next !== 1'b0) begin tests_failed++; $display("FAIL rd_resp8_dropped: got done %b want 0", done_next); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin tests_failed++; $display("FAIL rd_req100: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
      resp_delay = 1;
      step(); step();
      tests_run++; if (done_next !== 1'b1 || program_count_out !== 32'h100 || instruction_data_out !== 32'h0050_0113) begin tests_failed++; $display("FAIL rd_out100: got %b/%h/%h want 1/00000100/00500113", done_next, program_count_out, instruction_data_out); end
   endtask

   task automatic test_redirect_on_transfer();
      redirect = 1'b1; redirect_target = 32'h300;
      #1;
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rt_req_forced_low: got %b want 0", imem_req_valid); end
      step();
      redirect = 1'b0;
      #1;
      tests_run++; if (done_next !== 1'b0 || program_count_valid_out !== 1'b0) begin tests_failed++; $display("FAIL rt_entry_dropped: got done %b pcv %b want 0/0", done_next, program_count_valid_out); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin tests_failed++; $display("FAIL rt_req300: got %b/%h want 1/00000300", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_misaligned();
      redirect = 1'b1; redirect_target = 32'h102;
      step();
      redirect = 1'b0;
      #1;
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_noreq: got %b want 0", imem_req_valid); end
      step();
      tests_run++; if (done_next !== 1'b1 || program_count_out !== 32'h102 || program_count_valid_out !== 1'b1) begin tests_failed++; $display("FAIL mis_fault_out: got %b/%h/%b want 1/00000102/1", done_next, program_count_out, program_count_valid_out); end
      tests_run++; if (instruction_data_valid_out !== 1'b0) begin tests_failed++; $display("FAIL mis_idv: got %b want 0", instruction_data_valid_out); end
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_noreq2: got %b want 0", imem_req_valid); end
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++; if (done_next !== 1'b0 || imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_idle[%0d]: got done %b req %b want 0/0", i, done_next, imem_req_valid); end
      end
      redirect = 1'b1; redirect_target = 32'h200;
      step();
      redirect = 1'b0;
      #1;
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin tests_failed++; $display("FAIL mis_resume_req: got %b/%h want 1/00000200", imem_req_valid, imem_req_addr); end
      step(); step();
      tests_run++; if (done_next !== 1'b1 || program_count_out !== 32'h200 || instruction_data_out !== 32'h00A0_0193 || instruction_data_valid_out !== 1'b1) begin tests_failed++; $display("FAIL mis_resume_out: got %b/%h/%h/%b want 1/00000200/00a00193/1", done_next, program_count_out, instruction_data_out, instruction_data_valid_out); end
   endtask

   task automatic test_ready_wrap();
      imem_req_ready = 1'b0;
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_hold[%0d]: got %b/%h want 1/fffffffc", i, imem_req_valid, imem_req_addr); end
         step();
      end
      imem_req_ready = 1'b1;
      step();
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_wait: got %b want 0", imem_req_valid); end
      step();
      tests_run++; if (done_next !== 1'b1 || program_count_out !== 32'hFFFF_FFFC || instruction_data_out !== 32'h0000_006F) begin tests_failed++; $display("FAIL wrap_out: got %b/%h/%h want 1/fffffffc/0000006f", done_next, program_count_out, instruction_data_out); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next_addr: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_reset_in_wait();
      resp_delay = 3;
      step();
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_in_wait: got %b want 0", imem_req_valid); end
      rst = 1'b1; imem_req_ready = 1'b0;
      step();
      rst = 1'b0;
      #1;
      tests_run++; if (done_next !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL rw_after_rst: got done %b req %b/%h want 0/1/00000000", done_next, imem_req_valid, imem_req_addr); end
      step();
      tests_run++; if (imem_resp_valid !== 1'b1) begin tests_failed++; $display("FAIL rw_late_resp_present: got %b want 1", imem_resp_valid); end
      step();
      tests_run++; if (done_next !== 1'b0 || program_count_valid_out !== 1'b0) begin tests_failed++; $display("FAIL rw_late_resp_ignored: got done %b pcv %b want 0/0", done_next, program_count_valid_out); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL rw_req_reset_vector: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
      imem_req_ready = 1'b1; resp_delay = 1;
      step(); step();
      tests_run++; if (done_next !== 1'b1 || program_count_out !== 32'h0 || instruction_data_out !== 32'h0000_0013) begin tests_failed++; $display("FAIL rw_refetch: got %b/%h/%h want 1/00000000/00000013", done_next, program_count_out, instruction_data_out); end
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      rst             = 1'b1;
      next_stall      = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      pend            = 1'b0;
      pend_cnt        = 0;
      pend_addr       = 32'h0;
      resp_delay      = 1;

      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_drop();
      test_redirect_on_transfer();
      test_misaligned();
      test_ready_wrap();
      test_reset_in_wait();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
